cue_multi_collision_detector: RTL

//  Per-frame cue-tip vs. ball collision checker for up to NUM_BALLS balls; successor to the single-ball detector.

---
 rtl/cue_multi_collision_detector_if.sv | 37 +++
 rtl/cue_multi_collision_detector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cue_multi_collision_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : cue_multi_collision_detector_if
//  Description : Signal bundle between the cue tracker / ball physics side
//                (master) and the multi-ball cue collision detector (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cue_multi_collision_detector_if #(
    parameter int NUM_BALLS = 4,
    parameter int IDX_W     = 3
);
    logic                     frame_tick;
    logic [10:0]              front_x;
    logic [9:0]               front_y;
    logic [12*NUM_BALLS-1:0]  ball_x;
    logic [11*NUM_BALLS-1:0]  ball_y;
    logic [NUM_BALLS-1:0]     ball_active;
    logic                     busy;
    logic                     hit_valid;
    logic [IDX_W-1:0]         hit_ball;
    logic [10:0]              hit_x;
    logic [9:0]               hit_y;
    logic signed [11:0]       cue_dx;
    logic signed [10:0]       cue_dy;
    logic                     overrun;

    modport master (
        output frame_tick, front_x, front_y, ball_x, ball_y, ball_active,
        input  busy, hit_valid, hit_ball, hit_x, hit_y, cue_dx, cue_dy, overrun
    );

    modport slave (
        input  frame_tick, front_x, front_y, ball_x, ball_y, ball_active,
        output busy, hit_valid, hit_ball, hit_x, hit_y, cue_dx, cue_dy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/cue_multi_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : cue_multi_collision_detector
//  Description : Per-frame cue-tip vs. ball collision checker. After each
//                frame_tick the latched balls are tested one per clock; the
//                lowest-index hit is reported with the cue-tip velocity, and
//                a cooldown suppresses repeat strikes for HOLD_FRAMES frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module cue_multi_collision_detector #(
    parameter int NUM_BALLS   = 4,
    parameter int IDX_W       = 3,
    parameter int RADIUS      = 32,
    parameter int MARGIN      = 5,
    parameter int X_MAX       = 1023,
    parameter int Y_MAX       = 767,
    parameter int HOLD_FRAMES = 8
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    cue_multi_collision_detector_if.slave      bus
);
    localparam logic [1:0]      c_IDLE  = 2'd0;
    localparam logic [1:0]      c_SCAN  = 2'd1;
    localparam logic [1:0]      c_DONE  = 2'd2;
    localparam int              c_SLOTS = 1 << IDX_W;
    localparam int              c_CD_W  = 16;
    localparam logic [13:0]     c_RM    = 14'(RADIUS + MARGIN);
    localparam logic [13:0]     c_XMAX  = 14'(X_MAX);
    localparam logic [13:0]     c_YMAX  = 14'(Y_MAX);
    localparam logic [IDX_W-1:0]  c_LAST = IDX_W'(NUM_BALLS - 1);
    localparam logic [c_CD_W-1:0] c_HOLD = c_CD_W'(HOLD_FRAMES);

    logic [1:0]               state_q,    state_d;
    logic [IDX_W-1:0]         idx_q,      idx_d;
    logic                     found_q,    found_d;
    logic [IDX_W-1:0]         fidx_q,     fidx_d;
    logic [10:0]              fx_q,       fx_d;
    logic [9:0]               fy_q,       fy_d;
    logic [12*NUM_BALLS-1:0]  bx_q,       bx_d;
    logic [11*NUM_BALLS-1:0]  by_q,       by_d;
    logic [NUM_BALLS-1:0]     act_q,      act_d;
    logic [11:0]              dx_q,       dx_d;
    logic [10:0]              dy_q,       dy_d;
    logic [10:0]              prev_x_q,   prev_x_d;
    logic [9:0]               prev_y_q,   prev_y_d;
    logic                     first_q,    first_d;
    logic [c_CD_W-1:0]        cd_q,       cd_d;
    logic                     hv_q,       hv_d;
    logic [IDX_W-1:0]         hb_q,       hb_d;
    logic [10:0]              hx_q,       hx_d;
    logic [9:0]               hy_q,       hy_d;
    logic [11:0]              cdx_q,      cdx_d;
    logic [10:0]              cdy_q,      cdy_d;
    logic                     ovr_q,      ovr_d;

    // Latched ball data padded to a power-of-two table so idx_q indexes it exactly
    logic [11:0] w_bx_arr  [c_SLOTS];
    logic [10:0] w_by_arr  [c_SLOTS];
    logic        w_act_arr [c_SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < c_SLOTS; gi++) begin : g_slot
            if (gi < NUM_BALLS) begin : g_real
                assign w_bx_arr[gi]  = bx_q[12*gi +: 12];
                assign w_by_arr[gi]  = by_q[11*gi +: 11];
                assign w_act_arr[gi] = act_q[gi];
            end else begin : g_pad
                assign w_bx_arr[gi]  = 12'd0;
                assign w_by_arr[gi]  = 11'd0;
                assign w_act_arr[gi] = 1'b0;
            end
        end
    endgenerate

    // Capture box of the ball under test, clamped to the screen
    logic [13:0] w_bx, w_by, w_left, w_right, w_top, w_bottom, w_rsum, w_bsum, w_fx, w_fy;
    logic        w_hit;

    assign w_bx     = {2'b00, w_bx_arr[idx_q]};
    assign w_by     = {3'b000, w_by_arr[idx_q]};
    assign w_rsum   = w_bx + c_RM;
    assign w_bsum   = w_by + c_RM;
    assign w_left   = (w_bx < c_RM) ? 14'd0 : w_bx - c_RM;
    assign w_top    = (w_by < c_RM) ? 14'd0 : w_by - c_RM;
    assign w_right  = (w_rsum > c_XMAX) ? c_XMAX : w_rsum;
    assign w_bottom = (w_bsum > c_YMAX) ? c_YMAX : w_bsum;
    assign w_fx     = {3'b000, fx_q};
    assign w_fy     = {4'b0000, fy_q};
    assign w_hit    = w_act_arr[idx_q] && (w_left <= w_fx) && (w_fx <= w_right)
                      && (w_top <= w_fy) && (w_fy <= w_bottom);

    // Next-state logic: frame capture, sequential scan and hit/cooldown reporting
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        found_d  = found_q;
        fidx_d   = fidx_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        bx_d     = bx_q;
        by_d     = by_q;
        act_d    = act_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        first_d  = first_q;
        cd_d     = cd_q;
        hv_d     = 1'b0;
        hb_d     = hb_q;
        hx_d     = hx_q;
        hy_d     = hy_q;
        cdx_d    = cdx_q;
        cdy_d    = cdy_q;
        ovr_d    = ovr_q | (bus.frame_tick & (state_q != c_IDLE));
        case (state_q)
            c_IDLE: begin
                if (bus.frame_tick) begin
                    fx_d     = bus.front_x;
                    fy_d     = bus.front_y;
                    bx_d     = bus.ball_x;
                    by_d     = bus.ball_y;
                    act_d    = bus.ball_active;
                    dx_d     = first_q ? 12'd0 : ({1'b0, bus.front_x} - {1'b0, prev_x_q});
                    dy_d     = first_q ? 11'd0 : ({1'b0, bus.front_y} - {1'b0, prev_y_q});
                    prev_x_d = bus.front_x;
                    prev_y_d = bus.front_y;
                    first_d  = 1'b0;
                    idx_d    = '0;
                    found_d  = 1'b0;
                    state_d  = c_SCAN;
                end
            end
            c_SCAN: begin
                if (!found_q && w_hit) begin
                    found_d = 1'b1;
                    fidx_d  = idx_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == c_LAST) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                if (cd_q != '0) begin
                    cd_d = cd_q - c_CD_W'(1);
                    if (cd_q == c_CD_W'(1)) begin
                        hb_d = '0;
                    end
                end else if (found_q) begin
                    hv_d  = 1'b1;
                    hb_d  = fidx_q + IDX_W'(1);
                    hx_d  = fx_q;
                    hy_d  = fy_q;
                    cdx_d = dx_q;
                    cdy_d = dy_q;
                    cd_d  = c_HOLD;
                end else begin
                    hb_d = '0;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            idx_q    <= '0;
            found_q  <= 1'b0;
            fidx_q   <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            act_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            first_q  <= 1'b1;
            cd_q     <= '0;
            hv_q     <= 1'b0;
            hb_q     <= '0;
            hx_q     <= '0;
            hy_q     <= '0;
            cdx_q    <= '0;
            cdy_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            found_q  <= found_d;
            fidx_q   <= fidx_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            act_q    <= act_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            first_q  <= first_d;
            cd_q     <= cd_d;
            hv_q     <= hv_d;
            hb_q     <= hb_d;
            hx_q     <= hx_d;
            hy_q     <= hy_d;
            cdx_q    <= cdx_d;
            cdy_q    <= cdy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.busy      = (state_q != c_IDLE);
    assign bus.hit_valid = hv_q;
    assign bus.hit_ball  = hb_q;
    assign bus.hit_x     = hx_q;
    assign bus.hit_y     = hy_q;
    assign bus.cue_dx    = cdx_q;
    assign bus.cue_dy    = cdy_q;
    assign bus.overrun   = ovr_q;
endmodule
`default_nettype wire
